// File: rtl/texture_arbiter.sv
// texture_arbiter: round-robin front end that shares one texture_unit sampler between
// NUM_REQ shader requesters and routes returned texels back to the issuing requester.
module texture_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned CORD_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TEX_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*CORD_WIDTH-1:0] i_req_u,
  input  logic [NUM_REQ*CORD_WIDTH-1:0] i_req_v,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_tex_req_valid,
  output logic [CORD_WIDTH-1:0]         o_tex_u,
  output logic [CORD_WIDTH-1:0]         o_tex_v,
  input  logic                          i_tex_data_valid,
  input  logic [DATA_WIDTH-1:0]         i_tex_texel,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_texel,
  output logic                          o_err,
  output logic [15:0]                   o_issue_count
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  // Arbitration
  logic [IdW-1:0]        last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]    grant;
  logic [IdW-1:0]        grant_id;
  logic                  xfer;
  logic [CORD_WIDTH-1:0] sel_u, sel_v;

  // Issue stage
  logic                  tex_valid_q, tex_valid_d;
  logic [CORD_WIDTH-1:0] tex_u_q, tex_u_d;
  logic [CORD_WIDTH-1:0] tex_v_q, tex_v_d;
  logic [IdW-1:0]        issue_id_q, issue_id_d;
  logic [15:0]           count_q, count_d;

  // Tag pipeline, one stage per cycle of sampler latency
  logic [TEX_LATENCY-1:0]          tag_v_q, tag_v_d;
  logic [TEX_LATENCY-1:0][IdW-1:0] tag_id_q, tag_id_d;
  logic                            tail_v;
  logic [IdW-1:0]                  tail_id;

  // Response stage
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_texel_q, rsp_texel_d;
  logic                  err_q, err_d;
  logic                  rsp_hit;

  // Round-robin search starting one past the last granted requester.
  always_comb begin : arb_comb
    logic            found;
    int unsigned     idx;
    logic [IdW-1:0]  cand;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IdW'(idx);
      if (!found && i_req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
    end
    // No grant is offered while reset is held.
    if (rst) grant = '0;
    xfer = |grant;
  end

  // Select the granted requester's coordinates.
  always_comb begin
    sel_u = '0;
    sel_v = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_u = i_req_u[k*CORD_WIDTH +: CORD_WIDTH];
        sel_v = i_req_v[k*CORD_WIDTH +: CORD_WIDTH];
      end
    end
  end

  // Next state for arbiter pointer, issue registers and issue counter.
  always_comb begin
    last_grant_d = xfer ? grant_id : last_grant_q;
    tex_valid_d  = xfer;
    tex_u_d      = xfer ? sel_u : tex_u_q;
    tex_v_d      = xfer ? sel_v : tex_v_q;
    issue_id_d   = xfer ? grant_id : issue_id_q;
    count_d      = count_q + 16'(xfer);
  end

  // Tag pipeline always advances; the sampler cannot stall.
  always_comb begin
    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = tex_valid_q;
    tag_id_d[0] = issue_id_q;
    for (int unsigned i = 1; i < TEX_LATENCY; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  assign tail_v  = tag_v_q[TEX_LATENCY-1];
  assign tail_id = tag_id_q[TEX_LATENCY-1];
  assign rsp_hit = tail_v & i_tex_data_valid;

  // Route a matched texel to its owner; flag any tag/data disagreement.
  always_comb begin
    rsp_valid_d = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rsp_valid_d[k] = rsp_hit && (tail_id == IdW'(k));
    end
    rsp_texel_d = rsp_hit ? i_tex_texel : rsp_texel_q;
    err_d       = err_q | (tail_v ^ i_tex_data_valid);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IdW'(NUM_REQ - 1);
      tex_valid_q  <= 1'b0;
      tex_u_q      <= '0;
      tex_v_q      <= '0;
      issue_id_q   <= '0;
      count_q      <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_texel_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      tex_valid_q  <= tex_valid_d;
      tex_u_q      <= tex_u_d;
      tex_v_q      <= tex_v_d;
      issue_id_q   <= issue_id_d;
      count_q      <= count_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_texel_q  <= rsp_texel_d;
      err_q        <= err_d;
    end
  end

  assign o_req_ready     = grant;
  assign o_tex_req_valid = tex_valid_q;
  assign o_tex_u         = tex_u_q;
  assign o_tex_v         = tex_v_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_texel     = rsp_texel_q;
  assign o_err           = err_q;
  assign o_issue_count   = count_q;

endmodule

// File: tb/tb_texture_arbiter.sv
// Directed bench for texture_arbiter: one instance at default latency, one at TEX_LATENCY=3,
// each fed by a simple fixed-latency sampler model.
module tb_texture_arbiter;

  // Sampler model texel = {u,v} ^ KEY; u=0x4000,v=0x2000 maps to 0xDEADBEEF.
  localparam logic [31:0] KEY = 32'h9EAD_9EEF;

  logic clk;
  logic rst;

  logic [3:0]  a_req_valid, a_ready, a_rsp_valid;
  logic [63:0] a_req_u, a_req_v;
  logic        a_tex_valid, a_dv, a_err, a_inj;
  logic [15:0] a_tex_u, a_tex_v, a_count;
  logic [31:0] a_texel_in, a_rsp_texel;

  logic [3:0]  b_req_valid, b_ready, b_rsp_valid;
  logic [63:0] b_req_u, b_req_v;
  logic        b_tex_valid, b_dv, b_err;
  logic [15:0] b_tex_u, b_tex_v, b_count;
  logic [31:0] b_texel_in, b_rsp_texel;

  int n_checks = 0;
  int n_fail   = 0;

  texture_arbiter u_dut_a (
    .clk              (clk),
    .rst              (rst),
    .i_req_valid      (a_req_valid),
    .i_req_u          (a_req_u),
    .i_req_v          (a_req_v),
    .o_req_ready      (a_ready),
    .o_tex_req_valid  (a_tex_valid),
    .o_tex_u          (a_tex_u),
    .o_tex_v          (a_tex_v),
    .i_tex_data_valid (a_dv),
    .i_tex_texel      (a_texel_in),
    .o_rsp_valid      (a_rsp_valid),
    .o_rsp_texel      (a_rsp_texel),
    .o_err            (a_err),
    .o_issue_count    (a_count)
  );

  texture_arbiter #(.TEX_LATENCY(3)) u_dut_b (
    .clk              (clk),
    .rst              (rst),
    .i_req_valid      (b_req_valid),
    .i_req_u          (b_req_u),
    .i_req_v          (b_req_v),
    .o_req_ready      (b_ready),
    .o_tex_req_valid  (b_tex_valid),
    .o_tex_u          (b_tex_u),
    .o_tex_v          (b_tex_v),
    .i_tex_data_valid (b_dv),
    .i_tex_texel      (b_texel_in),
    .o_rsp_valid      (b_rsp_valid),
    .o_rsp_texel      (b_rsp_texel),
    .o_err            (b_err),
    .o_issue_count    (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] texel_of(input logic [15:0] u, input logic [15:0] v);
    return {u, v} ^ KEY;
  endfunction

  function automatic logic [15:0] u_of(input int k);
    return 16'(16'h1000 * (k + 1));
  endfunction

  function automatic logic [15:0] v_of(input int k);
    return 16'(16'h0100 * (k + 1));
  endfunction

  // Sampler model A: one-cycle latency, plus an injection hook for stray responses.
  logic        a_dv_q;
  logic [31:0] a_tx_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_dv_q <= 1'b0;
      a_tx_q <= '0;
    end else begin
      a_dv_q <= a_tex_valid;
      a_tx_q <= texel_of(a_tex_u, a_tex_v);
    end
  end
  assign a_dv       = a_dv_q | a_inj;
  assign a_texel_in = a_tx_q;

  // Sampler model B: three-cycle latency.
  logic [2:0]       b_dv_q;
  logic [2:0][31:0] b_tx_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_dv_q <= '0;
      b_tx_q <= '0;
    end else begin
      b_dv_q <= {b_dv_q[1:0], b_tex_valid};
      b_tx_q <= {b_tx_q[1:0], texel_of(b_tex_u, b_tex_v)};
    end
  end
  assign b_dv       = b_dv_q[2];
  assign b_texel_in = b_tx_q[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = '0; a_req_u = '0; a_req_v = '0; a_inj = 1'b0;
    b_req_valid = '0; b_req_u = '0; b_req_v = '0;

    // Reset state
    repeat (2) @(negedge clk);
    a_req_valid = 4'hF;
    b_req_valid = 4'hF;
    #1;
    chk("rst_ready_a", 32'(a_ready), 32'h0);
    chk("rst_ready_b", 32'(b_ready), 32'h0);
    chk("rst_tex_valid", 32'(a_tex_valid), 32'h0);
    chk("rst_tex_u", 32'(a_tex_u), 32'h0);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'h0);
    chk("rst_err", 32'(a_err), 32'h0);
    chk("rst_count", 32'(a_count), 32'h0);
    a_req_valid = '0;
    b_req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // TEX_LATENCY=3: back-to-back issues from requesters 1 then 2
    b_req_u[16 +: 16] = 16'hAAAA; b_req_v[16 +: 16] = 16'h1111;
    b_req_u[32 +: 16] = 16'h5555; b_req_v[32 +: 16] = 16'h2222;
    b_req_valid = 4'b0110;
    #1 chk("b_grant_first", 32'(b_ready), 32'b0010);
    @(negedge clk);
    b_req_valid = 4'b0100;
    #1;
    chk("b_grant_second", 32'(b_ready), 32'b0100);
    chk("b_tex_valid", 32'(b_tex_valid), 32'h1);
    chk("b_tex_u", 32'(b_tex_u), 32'hAAAA);
    @(negedge clk);
    b_req_valid = '0;
    repeat (2) @(negedge clk);
    #1 chk("b_rsp_early", 32'(b_rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("b_rsp0_valid", 32'(b_rsp_valid), 32'b0010);
    chk("b_rsp0_texel", b_rsp_texel, 32'hAAAA_1111 ^ KEY);
    @(negedge clk);
    #1;
    chk("b_rsp1_valid", 32'(b_rsp_valid), 32'b0100);
    chk("b_rsp1_texel", b_rsp_texel, 32'h5555_2222 ^ KEY);
    @(negedge clk);
    #1;
    chk("b_rsp_idle", 32'(b_rsp_valid), 32'h0);
    chk("b_no_err", 32'(b_err), 32'h0);
    chk("b_count", 32'(b_count), 32'd2);

    // All four requesters held valid for 8 cycles; first grant after reset is requester 0
    for (int k = 0; k < 4; k++) begin
      a_req_u[k*16 +: 16] = u_of(k);
      a_req_v[k*16 +: 16] = v_of(k);
    end
    a_req_valid = 4'hF;
    for (int n = 0; n <= 10; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 8) a_req_valid = '0;
      #1;
      if (n < 8) chk("rr_grant", 32'(a_ready), 32'(1 << (n % 4)));
      if (n >= 1 && n <= 8) chk("rr_tex_u", 32'(a_tex_u), 32'(u_of((n - 1) % 4)));
      if (n >= 3) begin
        chk("rr_rsp_valid", 32'(a_rsp_valid), 32'(1 << ((n - 3) % 4)));
        chk("rr_rsp_texel", a_rsp_texel, texel_of(u_of((n - 3) % 4), v_of((n - 3) % 4)));
      end
      if (n == 8) chk("rr_count", 32'(a_count), 32'd8);
    end

    // Single request from requester 2
    @(negedge clk);
    a_req_u[32 +: 16] = 16'h4000;
    a_req_v[32 +: 16] = 16'h2000;
    a_req_valid = 4'b0100;
    #1 chk("single_grant", 32'(a_ready), 32'b0100);
    @(negedge clk);
    a_req_valid = '0;
    #1;
    chk("single_tex_valid", 32'(a_tex_valid), 32'h1);
    chk("single_tex_u", 32'(a_tex_u), 32'h4000);
    chk("single_tex_v", 32'(a_tex_v), 32'h2000);
    chk("single_count", 32'(a_count), 32'd9);
    @(negedge clk);
    #1 chk("single_rsp_early", 32'(a_rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("single_rsp_valid", 32'(a_rsp_valid), 32'b0100);
    chk("single_rsp_texel", a_rsp_texel, 32'hDEAD_BEEF);

    // Sparse: requesters 1 and 3 (last grant was 2, so 3 goes first)
    @(negedge clk);
    a_req_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      if (n > 0) @(negedge clk);
      #1 chk("sparse_alt", 32'(a_ready), (n % 2 == 0) ? 32'b1000 : 32'b0010);
    end
    @(negedge clk);
    a_req_valid = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) @(negedge clk);
      #1 chk("sparse_lone", 32'(a_ready), 32'b0010);
    end
    @(negedge clk);
    a_req_valid = '0;
    repeat (4) @(negedge clk);
    #1 chk("sparse_no_err", 32'(a_err), 32'h0);

    // Reset in the middle of traffic
    @(negedge clk);
    a_req_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1 chk("pre_rst_tex_valid", 32'(a_tex_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(a_ready), 32'h0);
    chk("mid_rst_tex_valid", 32'(a_tex_valid), 32'h0);
    chk("mid_rst_tex_u", 32'(a_tex_u), 32'h0);
    chk("mid_rst_tex_v", 32'(a_tex_v), 32'h0);
    chk("mid_rst_rsp_valid", 32'(a_rsp_valid), 32'h0);
    chk("mid_rst_rsp_texel", a_rsp_texel, 32'h0);
    chk("mid_rst_count", 32'(a_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_grant0", 32'(a_ready), 32'b0001);
    @(negedge clk);
    a_req_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    chk("post_rst_count", 32'(a_count), 32'd1);
    chk("post_rst_no_err", 32'(a_err), 32'h0);

    // Stray response with an empty tag pipeline
    @(negedge clk);
    a_inj = 1'b1;
    @(negedge clk);
    a_inj = 1'b0;
    #1;
    chk("stray_err", 32'(a_err), 32'h1);
    chk("stray_no_rsp", 32'(a_rsp_valid), 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("stray_err_sticky", 32'(a_err), 32'h1);
    chk("stray_no_rsp_late", 32'(a_rsp_valid), 32'h0);

    // Issue counter wrap: 0xFFFF transfers from a lone requester, then one more
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_req_valid = 4'b0001;
    #1 chk("wrap_lone_grant", 32'(a_ready), 32'b0001);
    repeat (65535) @(negedge clk);
    #1 chk("wrap_lone_grant_late", 32'(a_ready), 32'b0001);
    a_req_valid = '0;
    #1 chk("wrap_count_ffff", 32'(a_count), 32'hFFFF);
    @(negedge clk);
    a_req_valid = 4'b0001;
    @(negedge clk);
    a_req_valid = '0;
    #1 chk("wrap_count_zero", 32'(a_count), 32'h0);
    repeat (3) @(negedge clk);
    #1 chk("wrap_no_err", 32'(a_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/texture_arbiter.md
# texture_arbiter

Round-robin arbiter that shares one `texture_unit` sampler between `NUM_REQ` shader requesters. It accepts UV requests over per-requester valid/ready handshakes and issues at most one request per cycle to the sampler. It tracks each request's owner through a tag pipeline matched to the sampler latency, then routes each returned texel back to the requester that issued it. It sits between the shader cores and the `texture_unit` instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2..16).
- `CORD_WIDTH`, 16: UV coordinate width, same format as `texture_unit`.
- `DATA_WIDTH`, 32: texel (RGBA) width.
- `TEX_LATENCY`, 1: cycles from `o_tex_req_valid` to the matching `i_tex_data_valid` (≥1).
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_req_valid`  in  NUM_REQ  per-requester request valid.
- `i_req_u`  in  NUM_REQ*CORD_WIDTH  packed u coordinates; requester k occupies slice k.
- `i_req_v`  in  NUM_REQ*CORD_WIDTH  packed v coordinates.
- `o_req_ready`  out  NUM_REQ  one-hot or zero; the grant.
- `o_tex_req_valid`  out  1  request to the sampler.
- `o_tex_u`, `o_tex_v`  out  CORD_WIDTH  coordinates to the sampler.
- `i_tex_data_valid`  in  1  sampler response valid.
- `i_tex_texel`  in  DATA_WIDTH  sampler texel.
- `o_rsp_valid`  out  NUM_REQ  one-hot or zero; response strobe to a requester.
- `o_rsp_texel`  out  DATA_WIDTH  texel, shared by all requesters.
- `o_err`  out  1  sticky tag/response mismatch flag.
- `o_issue_count`  out  16  count of issued requests; wraps.

## Operation
- **Arbitration:** combinational round-robin over `i_req_valid`.
  - Search starts at `last_grant+1` modulo `NUM_REQ`.
  - `o_req_ready` = one-hot of the first valid requester found; zero if none is valid.
  - A transfer occurs when `i_req_valid[k] & o_req_ready[k]`.
  - `last_grant` updates only on a transfer.
- **Issue stage:** registered.
  - On a transfer: `o_tex_req_valid`=1 next cycle, with the granted requester's u/v.
  - Otherwise `o_tex_req_valid`=0 next cycle, and u/v hold their last values.
- **Tag pipeline:**
  - Depth is `TEX_LATENCY` stages of {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {`o_tex_req_valid`, issued id}.
  - The tail is aligned with `i_tex_data_valid`.
  - The sampler has no backpressure, so the pipeline always advances.
- **Response stage:** registered.
  - When tail valid & `i_tex_data_valid`: `o_rsp_valid[tail_id]`=1 next cycle and `o_rsp_texel`=`i_tex_texel`.
  - `o_rsp_texel` holds its value otherwise.
- **Mismatch:**
  - Tail valid XOR `i_tex_data_valid` sets `o_err`. Cleared only by reset.
  - An unexpected texel is dropped. A missing texel produces no response.
- `o_issue_count` increments on every transfer and wraps 0xFFFF→0.
- Requesters must hold u/v and `i_req_valid` stable until granted. The arbiter does not re-check this.

## Timing
- **Reset (asynchronous, takes effect immediately):**
  - `o_tex_req_valid`=0, `o_rsp_valid`=0, `o_tex_u`=`o_tex_v`=0, `o_rsp_texel`=0, `o_err`=0, `o_issue_count`=0.
  - Tag pipeline is all invalid.
  - `last_grant`=`NUM_REQ-1`, so requester 0 has top priority after reset.
- `o_req_ready` is combinational from `i_req_valid` and `last_grant`. It is 0 while `rst` is high.
- **Throughput:** one transfer per cycle sustained.
- **Latency:** transfer at cycle T → `o_tex_req_valid` at T+1 → `i_tex_data_valid` at T+1+`TEX_LATENCY` → `o_rsp_valid` at T+2+`TEX_LATENCY`. This is T+3 at the defaults.
- **Fairness:** with all requesters valid, grants rotate 0,1,…,NUM_REQ-1,0,… and each requester waits at most `NUM_REQ-1` cycles.
- **Single requester:** a lone valid requester is granted every cycle.
- **Reset mid-operation:** in-flight tags are discarded. Responses arriving after reset deassertion with no matching tag set `o_err`, which is expected and is the caller's concern.
- No combinational path from `i_tex_*` to any output.

## Test plan
- **Reset values:** assert `rst` mid-traffic → all outputs return to their reset values in the same cycle; after release, the first grant with all requesters valid goes to requester 0.
- **Single request, defaults:** requester 2 requests u=0x4000, v=0x2000 at T; the sampler model returns 0xDEADBEEF one cycle after its request → `o_tex_req_valid` at T+1 with the same u/v; `o_rsp_valid`=4'b0100 and texel 0xDEADBEEF at T+3.
- **All four requesters held valid for 8 cycles** → grant sequence 0,1,2,3,0,1,2,3; `o_issue_count`=8; each response is routed to the correct requester in order.
- **Sparse requests:** only requesters 1 and 3 valid → grants alternate 1,3,1,3; requester 3 dropping valid → requester 1 is granted every cycle.
- **Latency parameter:** `TEX_LATENCY`=3, back-to-back issues with distinct texels → each response appears 5 cycles after its grant, with the correct id and no `o_err`.
- **Mismatch and counter wrap:**
  - Inject `i_tex_data_valid` with an empty tag pipeline → `o_err`=1 and stays 1; no `o_rsp_valid` is produced.
  - Preload 0xFFFF transfers → the next transfer wraps `o_issue_count` to 0.
